// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID decode, load-use stall detection and EX/MEM/WB control pipeline
module ctrl_pipe #(
    parameter int REG_W         = 5,
    parameter int STALL_ON_LOAD = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             flush_ex,
    output logic             stall,
    output logic [11:0]      ex_ctrl,
    output logic             ex_valid,
    output logic             ex_illegal,
    output logic [REG_W-1:0] ex_rd,
    output logic             mem_valid,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             mem_reg_write,
    output logic [REG_W-1:0] mem_rd,
    output logic             wb_valid,
    output logic             wb_mem_to_reg,
    output logic             wb_reg_write,
    output logic [REG_W-1:0] wb_rd,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Bit positions inside the 12-bit control bundle
    localparam int B_MEM_READ   = 8;
    localparam int B_MEM_TO_REG = 7;
    localparam int B_MEM_WRITE  = 4;
    localparam int B_REG_WRITE  = 2;

    localparam logic             STALL_EN = (STALL_ON_LOAD != 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [11:0] dec_ctrl;
    logic        dec_illegal;
    logic        use_rs1;
    logic        use_rs2;
    logic        hazard;
    logic        accept;

    always_comb begin
        dec_ctrl    = 12'b0;
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        case (id_opcode)
            OP_R:      begin dec_ctrl = 12'b00_000_10_001_00; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_I:      begin dec_ctrl = 12'b00_000_11_011_00; use_rs1 = 1'b1; end
            OP_LOAD:   begin dec_ctrl = 12'b00_011_00_011_00; use_rs1 = 1'b1; end
            OP_STORE:  begin dec_ctrl = 12'b00_000_00_110_00; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_BRANCH: begin dec_ctrl = 12'b01_100_01_000_00; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_JAL:    begin dec_ctrl = 12'b10_000_11_011_00; end
            OP_JALR:   begin dec_ctrl = 12'b11_000_11_011_00; use_rs1 = 1'b1; end
            OP_LUI:    begin dec_ctrl = 12'b00_000_00_011_01; end
            OP_AUIPC:  begin dec_ctrl = 12'b00_000_00_011_10; end
            default:   begin dec_illegal = 1'b1; end
        endcase
    end

    // An rd=0 load never stalls: x0 is never really written
    assign hazard = id_valid & ex_valid & ex_ctrl[B_MEM_READ] & (ex_rd != '0)
                  & ((use_rs1 & (ex_rd == id_rs1)) | (use_rs2 & (ex_rd == id_rs2)));
    assign stall  = hazard & STALL_EN & ~flush_ex & ~rst;
    assign accept = id_valid & ~stall & ~flush_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_illegal    <= 1'b0;
            ex_ctrl       <= 12'b0;
            ex_rd         <= '0;
            mem_valid     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= '0;
            wb_valid      <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            stall_count   <= '0;
        end else begin
            if (accept) begin
                ex_valid   <= 1'b1;
                ex_illegal <= dec_illegal;
                ex_ctrl    <= dec_ctrl;
                ex_rd      <= id_rd;
            end else begin
                ex_valid   <= 1'b0;
                ex_illegal <= 1'b0;
                ex_ctrl    <= 12'b0;
                ex_rd      <= '0;
            end
            // Later stages never hold: a flush only kills the instruction in ID
            mem_valid     <= ex_valid;
            mem_read      <= ex_ctrl[B_MEM_READ];
            mem_write     <= ex_ctrl[B_MEM_WRITE];
            mem_to_reg    <= ex_ctrl[B_MEM_TO_REG];
            mem_reg_write <= ex_ctrl[B_REG_WRITE];
            mem_rd        <= ex_rd;
            wb_valid      <= mem_valid;
            wb_mem_to_reg <= mem_to_reg;
            wb_reg_write  <= mem_reg_write;
            wb_rd         <= mem_rd;
            if (stall && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized and directed checks of ctrl_pipe against a record-queue model
module tb_ctrl_pipe;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       flush_ex;

    logic        s0, s1, s2;
    logic [11:0] c0, c1, c2;
    logic        ev0, ev1, ev2, ei0, ei1, ei2;
    logic [4:0]  er0, er1, er2, mr0, mr1, mr2, wr0, wr1, wr2;
    logic        mv0, mv1, mv2, mrd0, mrd1, mrd2, mw0, mw1, mw2;
    logic        mm0, mm1, mm2, mrw0, mrw1, mrw2;
    logic        wv0, wv1, wv2, wm0, wm1, wm2, ww0, ww1, ww2;
    logic [31:0] cnt0, cnt2;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    ctrl_pipe u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush_ex(flush_ex),
        .stall(s0), .ex_ctrl(c0), .ex_valid(ev0), .ex_illegal(ei0), .ex_rd(er0),
        .mem_valid(mv0), .mem_read(mrd0), .mem_write(mw0), .mem_to_reg(mm0),
        .mem_reg_write(mrw0), .mem_rd(mr0), .wb_valid(wv0), .wb_mem_to_reg(wm0),
        .wb_reg_write(ww0), .wb_rd(wr0), .stall_count(cnt0)
    );

    ctrl_pipe #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush_ex(flush_ex),
        .stall(s1), .ex_ctrl(c1), .ex_valid(ev1), .ex_illegal(ei1), .ex_rd(er1),
        .mem_valid(mv1), .mem_read(mrd1), .mem_write(mw1), .mem_to_reg(mm1),
        .mem_reg_write(mrw1), .mem_rd(mr1), .wb_valid(wv1), .wb_mem_to_reg(wm1),
        .wb_reg_write(ww1), .wb_rd(wr1), .stall_count(cnt1)
    );

    ctrl_pipe #(.STALL_ON_LOAD(0)) u2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush_ex(flush_ex),
        .stall(s2), .ex_ctrl(c2), .ex_valid(ev2), .ex_illegal(ei2), .ex_rd(er2),
        .mem_valid(mv2), .mem_read(mrd2), .mem_write(mw2), .mem_to_reg(mm2),
        .mem_reg_write(mrw2), .mem_rd(mr2), .wb_valid(wv2), .wb_mem_to_reg(wm2),
        .wb_reg_write(ww2), .wb_rd(wr2), .stall_count(cnt2)
    );

    typedef struct packed {
        logic        v;
        logic        ill;
        logic [11:0] c;
        logic [4:0]  rd;
    } stg_t;

    // pipe[m][k]: m=0 stall detection on, m=1 off; k=0 EX, 1 MEM, 2 WB
    stg_t   pipe [2][3];
    longint cnt;
    bit     chk_en = 1'b0;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] dec(input logic [6:0] op);
        case (op)
            OP_R:      return {1'b0, 12'b00_000_10_001_00};
            OP_I:      return {1'b0, 12'b00_000_11_011_00};
            OP_LOAD:   return {1'b0, 12'b00_011_00_011_00};
            OP_STORE:  return {1'b0, 12'b00_000_00_110_00};
            OP_BRANCH: return {1'b0, 12'b01_100_01_000_00};
            OP_JAL:    return {1'b0, 12'b10_000_11_011_00};
            OP_JALR:   return {1'b0, 12'b11_000_11_011_00};
            OP_LUI:    return {1'b0, 12'b00_000_00_011_01};
            OP_AUIPC:  return {1'b0, 12'b00_000_00_011_10};
            default:   return {1'b1, 12'b0};
        endcase
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_STORE, OP_BRANCH};
    endfunction

    function automatic bit exp_stall(input int m);
        stg_t e;
        e = pipe[m][0];
        if (m != 0 || rst || flush_ex || !id_valid) return 1'b0;
        if (!(e.v && e.c[8] && e.rd != 0)) return 1'b0;
        return (reads_rs1(id_opcode) && e.rd == id_rs1) || (reads_rs2(id_opcode) && e.rd == id_rs2);
    endfunction

    function automatic logic [36:0] exp_pipe(input int m);
        stg_t e, x, w;
        e = pipe[m][0];
        x = pipe[m][1];
        w = pipe[m][2];
        return {e.v, e.ill, e.c, e.rd, x.v, x.c[8], x.c[4], x.c[7], x.c[2], x.rd,
                w.v, w.c[7], w.c[2], w.rd};
    endfunction

    task automatic model_step();
        stg_t        n;
        logic [12:0] d;
        bit          s;
        for (int m = 0; m < 2; m++) begin
            s = exp_stall(m);
            n = '0;
            if (!rst && id_valid && !s && !flush_ex) begin
                d     = dec(id_opcode);
                n.v   = 1'b1;
                n.ill = d[12];
                n.c   = d[11:0];
                n.rd  = id_rd;
            end
            pipe[m][2] = rst ? '0 : pipe[m][1];
            pipe[m][1] = rst ? '0 : pipe[m][0];
            pipe[m][0] = n;
            if (m == 0) cnt = rst ? 0 : cnt + longint'(s);
        end
        if (rst) chk_en = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("u0_stall", s0, exp_stall(0));
            chk("u0_pipe", {ev0, ei0, c0, er0, mv0, mrd0, mw0, mm0, mrw0, mr0, wv0, wm0, ww0, wr0}, exp_pipe(0));
            chk("u0_count", cnt0, cnt[31:0]);
            chk("u1_stall", s1, exp_stall(0));
            chk("u1_pipe", {ev1, ei1, c1, er1, mv1, mrd1, mw1, mm1, mrw1, mr1, wv1, wm1, ww1, wr1}, exp_pipe(0));
            chk("u1_count", cnt1, (cnt > 3) ? 3 : cnt);
            chk("u2_stall", s2, exp_stall(1));
            chk("u2_pipe", {ev2, ei2, c2, er2, mv2, mrd2, mw2, mm2, mrw2, mr2, wv2, wm2, ww2, wr2}, exp_pipe(1));
            chk("u2_count", cnt2, 0);
        end
    end

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic fl, input logic r);
        @(posedge clk);
        #2;
        id_valid  = v;
        id_opcode = op;
        id_rs1    = a;
        id_rs2    = b;
        id_rd     = d;
        flush_ex  = fl;
        rst       = r;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    logic [6:0] ops [11];

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; flush_ex = 1'b0;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_LOAD, OP_SYS};
        repeat (3) drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst_ex_valid", ev0, 0);
        chk("rst_wb_valid", wv0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_stall", s0, 0);

        // add rd=3 straight out of reset
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("add_ex_ctrl", c0, 12'b000001000100);
        chk("add_ex_rd", er0, 3);
        idle();
        @(negedge clk);
        chk("add_mem_reg_write", mrw0, 1);
        idle();
        @(negedge clk);
        chk("add_wb_rd", wr0, 3);
        chk("add_wb_valid", wv0, 1);

        // load-use stall
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        drive(1'b1, OP_R, 5'd5, 5'd2, 5'd7, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_stall", s0, 1);
        chk("lu_stall_disabled", s2, 0);
        drive(1'b1, OP_R, 5'd5, 5'd2, 5'd7, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_ex_bubble", ev0, 0);
        chk("lu_stall_clear", s0, 0);
        idle();
        @(negedge clk);
        chk("lu_ex_valid", ev0, 1);
        chk("lu_ex_rd", er0, 7);
        chk("lu_count", cnt0, 1);

        // lui ignores rs1; rd=0 load never stalls
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        drive(1'b1, OP_LUI, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0);
        @(negedge clk);
        chk("lui_no_stall", s0, 0);
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        chk("x0_no_stall", s0, 0);

        // flush beats stall
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        drive(1'b1, OP_R, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_stall", s0, 0);
        idle();
        @(negedge clk);
        chk("flush_ex_valid", ev0, 0);
        chk("flush_mem_read", {mv0, mrd0}, 2'b11);
        chk("flush_count", cnt0, 1);

        // illegal opcode
        drive(1'b1, OP_SYS, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("ill_flag", ei0, 1);
        chk("ill_ctrl", c0, 0);
        drive(1'b0, OP_SYS, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("ill_invalid", ei0, 0);

        // five more stalls: saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
            drive(1'b1, OP_R, 5'd5, 5'd2, 5'd7, 1'b0, 1'b0);
            @(negedge clk);
            chk("sat_stall", s0, 1);
            idle();
        end
        idle();
        @(negedge clk);
        chk("sat_count_wide", cnt0, 6);
        chk("sat_count_narrow", cnt1, 3);

        // reset mid-flight drops everything in one edge
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        drive(1'b1, OP_LOAD, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("midrst_valids", {ev0, mv0, wv0}, 0);
        chk("midrst_count", cnt0, 0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 8, ops[$urandom_range(0, 10)] ^ (($urandom_range(0, 19) == 0) ? 7'($urandom) : 7'd0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end
        idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
